dram_phase_latch: RTL and testbench
===================================

# dram_phase_latch

Parametrised successor to the SAM-side clock-enable divider and RAS/CAS address/data latch logic in the CoCo2 top level. Generates the master clock-enable from the fast system clock, reconstructs the full RAM address from the multiplexed row/column bus, classifies refresh-only cycles, and captures RAM read data on both the Q (video) and E (CPU) phases. Sits between the mc6883 SAM, the dual-port RAM and the VDG/CPU data paths.

## Interface
Parameters:
- DIV, 4: clk cycles per clock-enable period; legal range 2..16.
- ROW_W, 8: row address bits latched on the RAS fall.
- COL_W, 8: column address bits latched on the CAS fall.
- MA_W, 8: multiplexed address bus width; must be >= max(ROW_W, COL_W).
- DATA_W, 8: RAM data width.
- CAP_EDGE, 0: Q edge for video capture; 0 = rising, 1 = falling.

Ports:
- clk  in  1  system clock (57.272 MHz).
- reset  in  1  asynchronous, active-low reset.
- ena_out  out  1  one-clk clock-enable pulse, every DIV clks.
- ras_n  in  1  row strobe from the SAM.
- cas_n  in  1  column strobe from the SAM.
- ma  in  MA_W  multiplexed RAM address from the SAM.
- e  in  1  CPU E clock.
- q  in  1  CPU Q clock.
- mem_q  in  DATA_W  RAM read data.
- addr  out  ROW_W+COL_W  assembled address {col, row}.
- addr_vld  out  1  one-clk pulse when addr updates.
- refresh  out  1  one-clk pulse on a refresh-only (RAS without CAS) cycle.
- cas_err  out  1  one-clk pulse on a CAS fall with no row latched.
- vid_data  out  DATA_W  data captured on the selected Q edge.
- vid_vld  out  1  one-clk pulse when vid_data updates.
- cpu_data  out  DATA_W  data captured on the E fall.
- cpu_vld  out  1  one-clk pulse when cpu_data updates.

## Operation
- Divider: cnt runs 0..DIV-1 and wraps. ena_out is registered high for exactly one clk when cnt==DIV-1.
- All inputs (ras_n, cas_n, e, q, ma, mem_q) are sampled only on clks where ena_out is high. Edge history registers are ras_r, cas_r (reset 1), e_r and q_r (reset 0). History updates on every ena.
- Row: a ras_n fall (ras_n==0, ras_r==1) sets row <= ma[ROW_W-1:0] and row_ok <= 1.
- Column: a cas_n fall with row_ok==1 sets addr <= {ma[COL_W-1:0], row}, pulses addr_vld, and clears row_ok.
- A cas_n fall with row_ok==0 pulses cas_err. addr is unchanged.
- Simultaneous ras_n fall and cas_n fall on the same ena: the row is latched, cas_err pulses, row_ok ends at 1, and addr is unchanged.
- Refresh: a ras_n rise (ras_n==1, ras_r==0) while row_ok==1 (no CAS since the row) pulses refresh and clears row_ok.
- A ras_n rise after a completed access clears nothing extra and produces no pulse.
- Video capture: on the selected q edge, vid_data <= mem_q and vid_vld pulses.
- CPU capture: on an e fall (e==0, e_r==1), cpu_data <= mem_q and cpu_vld pulses.
- Q and E events on the same ena are independent; both captures occur.

## Timing
- Reset values (asserted asynchronously): cnt=0, ena_out=0, all pulses 0, addr=0, vid_data=0, cpu_data=0, row=0, row_ok=0, ras_r=cas_r=1, e_r=q_r=0.
- After reset is released, the first ena_out is high during clk cycle DIV. It then recurs every DIV clks.
- Every output is registered.
- Pulse outputs rise at the clk edge that ends the ena cycle and are high for exactly 1 clk. They never last longer, even when DIV==2.
- Data/address latency: an input stable during ena cycle N is visible on the outputs in cycle N+1.
- Reset deasserted mid-access: row_ok is 0, so the first CAS fall after reset gives cas_err, not addr_vld.
- The reset release is not synchronised internally; the integrator provides a release synchronous to clk.

## Test plan
- DIV=4, reset released at t0 -> ena_out high in clks 4, 8, 12, … and low in all other clks. Repeat with DIV=2 and DIV=7.
- RAS fall with ma=0x34, then CAS fall with ma=0x12 -> addr=0x1234 with a single addr_vld pulse one clk after the CAS ena. refresh=0.
- RAS fall with ma=0x55, RAS rise with no CAS -> refresh pulses once, addr unchanged, and a following lone CAS fall gives cas_err=1.
- mem_q=0xA5 at a Q rise (CAP_EDGE=0) and mem_q=0x3C at an E fall -> vid_data=0xA5 with vid_vld, cpu_data=0x3C with cpu_vld. Repeat with CAP_EDGE=1: capture moves to the Q fall.
- RAS and CAS fall on the same ena with ma=0x77 -> cas_err pulse, no addr_vld. A subsequent CAS fall with ma=0x01 gives addr=0x0177.
- Assert reset between the RAS and CAS falls -> all outputs return to reset values immediately. After release, the CAS fall gives cas_err and the divider restarts with ena_out at clk DIV.

Source files
------------

// File: rtl/dram_phase_latch.sv
// SAM-side clock-enable divider with RAS/CAS address reassembly, refresh
// classification and dual-phase (Q video / E cpu) RAM read-data capture.

// Edge-qualified capture register: samples strb_i on every ena, latches data on the chosen edge.
module dram_phase_cap #(
  parameter int DATA_W = 8,
  parameter bit FALL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic              strb_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o
);
  logic              strb_q;
  logic              hit;
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q;

  always_comb begin
    hit    = FALL ? (~strb_i & strb_q) : (strb_i & ~strb_q);
    data_d = data_q;
    if (ena_i && hit) data_d = data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q <= 1'b0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (ena_i) strb_q <= strb_i;
      data_q <= data_d;
      vld_q  <= ena_i & hit;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
endmodule

module dram_phase_latch #(
  parameter int DIV      = 4,  // 2..16
  parameter int ROW_W    = 8,
  parameter int COL_W    = 8,
  parameter int MA_W     = 8,  // >= max(ROW_W, COL_W)
  parameter int DATA_W   = 8,
  parameter int CAP_EDGE = 0   // 0 = Q rise, 1 = Q fall
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ena_out,
  input  logic                   ras_n,
  input  logic                   cas_n,
  input  logic [MA_W-1:0]        ma,
  input  logic                   e,
  input  logic                   q,
  input  logic [DATA_W-1:0]      mem_q,
  output logic [ROW_W+COL_W-1:0] addr,
  output logic                   addr_vld,
  output logic                   refresh,
  output logic                   cas_err,
  output logic [DATA_W-1:0]      vid_data,
  output logic                   vid_vld,
  output logic [DATA_W-1:0]      cpu_data,
  output logic                   cpu_vld
);
  localparam int CNT_W  = $clog2(DIV);
  localparam int ADDR_W = ROW_W + COL_W;

  typedef struct packed {
    logic ras_fall;
    logic ras_rise;
    logic cas_fall;
  } strb_evt_t;

  // ---------------- divider ----------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ena_q;
  logic             wrap;

  always_comb begin
    wrap  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ena_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ena_q <= wrap;
    end
  end

  assign ena_out = ena_q;

  // ---------------- address path ----------------
  logic              ras_r_q, cas_r_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              row_ok_q, row_ok_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_vld_d, refresh_d, cas_err_d;
  logic              addr_vld_q, refresh_q, cas_err_q;
  strb_evt_t         evt;

  always_comb begin
    evt.ras_fall = ~ras_n &  ras_r_q;
    evt.ras_rise =  ras_n & ~ras_r_q;
    evt.cas_fall = ~cas_n &  cas_r_q;

    row_d      = row_q;
    row_ok_d   = row_ok_q;
    addr_d     = addr_q;
    addr_vld_d = 1'b0;
    refresh_d  = 1'b0;
    cas_err_d  = 1'b0;

    if (ena_q) begin
      if (evt.ras_fall) begin
        row_d    = ma[ROW_W-1:0];
        row_ok_d = 1'b1;
        // A CAS landing with its own RAS has no prior row to pair with.
        cas_err_d = evt.cas_fall;
      end else if (evt.cas_fall) begin
        if (row_ok_q) begin
          addr_d     = {ma[COL_W-1:0], row_q};
          addr_vld_d = 1'b1;
          row_ok_d   = 1'b0;
        end else begin
          cas_err_d = 1'b1;
        end
      end
      // RAS closing on an unconsumed row means the SAM only refreshed it.
      if (evt.ras_rise && row_ok_q && !evt.cas_fall) begin
        refresh_d = 1'b1;
        row_ok_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_r_q    <= 1'b1;
      cas_r_q    <= 1'b1;
      row_q      <= '0;
      row_ok_q   <= 1'b0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      refresh_q  <= 1'b0;
      cas_err_q  <= 1'b0;
    end else begin
      if (ena_q) begin
        ras_r_q <= ras_n;
        cas_r_q <= cas_n;
      end
      row_q      <= row_d;
      row_ok_q   <= row_ok_d;
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      refresh_q  <= refresh_d;
      cas_err_q  <= cas_err_d;
    end
  end

  assign addr     = addr_q;
  assign addr_vld = addr_vld_q;
  assign refresh  = refresh_q;
  assign cas_err  = cas_err_q;

  // ---------------- data capture ----------------
  dram_phase_cap #(.DATA_W(DATA_W), .FALL(CAP_EDGE != 0)) u_vid (
    .clk   (clk),
    .rst_n (reset),
    .ena_i (ena_q),
    .strb_i(q),
    .data_i(mem_q),
    .data_o(vid_data),
    .vld_o (vid_vld)
  );

  dram_phase_cap #(.DATA_W(DATA_W), .FALL(1'b1)) u_cpu (
    .clk   (clk),
    .rst_n (reset),
    .ena_i (ena_q),
    .strb_i(e),
    .data_i(mem_q),
    .data_o(cpu_data),
    .vld_o (cpu_vld)
  );
endmodule

// File: tb/tb_dram_phase_latch.sv
// Directed bench: DIV=4 main instance, DIV=4/Q-fall capture twin, DIV=2 and DIV=7 divider instances.
module tb_dram_phase_latch;
  logic       clk = 1'b0;
  logic       reset;
  logic       ras_n, cas_n, e, q;
  logic [7:0] ma, mem_q;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  // main DUT: DIV=4, CAP_EDGE=0
  logic        a_ena, a_avld, a_ref, a_cerr, a_vvld, a_cvld;
  logic [15:0] a_addr;
  logic [7:0]  a_vid, a_cpu;
  // twin: DIV=4, CAP_EDGE=1
  logic        b_ena, b_avld, b_ref, b_cerr, b_vvld, b_cvld;
  logic [15:0] b_addr;
  logic [7:0]  b_vid, b_cpu;
  // DIV=2
  logic        c_ena, c_avld, c_ref, c_cerr, c_vvld, c_cvld;
  logic [15:0] c_addr;
  logic [7:0]  c_vid, c_cpu;
  // DIV=7
  logic        d_ena, d_avld, d_ref, d_cerr, d_vvld, d_cvld;
  logic [15:0] d_addr;
  logic [7:0]  d_vid, d_cpu;

  dram_phase_latch #(.DIV(4), .CAP_EDGE(0)) u_dut (
    .clk(clk), .reset(reset), .ena_out(a_ena), .ras_n(ras_n), .cas_n(cas_n), .ma(ma),
    .e(e), .q(q), .mem_q(mem_q), .addr(a_addr), .addr_vld(a_avld), .refresh(a_ref),
    .cas_err(a_cerr), .vid_data(a_vid), .vid_vld(a_vvld), .cpu_data(a_cpu), .cpu_vld(a_cvld));

  dram_phase_latch #(.DIV(4), .CAP_EDGE(1)) u_fall (
    .clk(clk), .reset(reset), .ena_out(b_ena), .ras_n(ras_n), .cas_n(cas_n), .ma(ma),
    .e(e), .q(q), .mem_q(mem_q), .addr(b_addr), .addr_vld(b_avld), .refresh(b_ref),
    .cas_err(b_cerr), .vid_data(b_vid), .vid_vld(b_vvld), .cpu_data(b_cpu), .cpu_vld(b_cvld));

  dram_phase_latch #(.DIV(2)) u_d2 (
    .clk(clk), .reset(reset), .ena_out(c_ena), .ras_n(ras_n), .cas_n(cas_n), .ma(ma),
    .e(e), .q(q), .mem_q(mem_q), .addr(c_addr), .addr_vld(c_avld), .refresh(c_ref),
    .cas_err(c_cerr), .vid_data(c_vid), .vid_vld(c_vvld), .cpu_data(c_cpu), .cpu_vld(c_cvld));

  dram_phase_latch #(.DIV(7)) u_d7 (
    .clk(clk), .reset(reset), .ena_out(d_ena), .ras_n(ras_n), .cas_n(cas_n), .ma(ma),
    .e(e), .q(q), .mem_q(mem_q), .addr(d_addr), .addr_vld(d_avld), .refresh(d_ref),
    .cas_err(d_cerr), .vid_data(d_vid), .vid_vld(d_vvld), .cpu_data(d_cpu), .cpu_vld(d_cvld));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive inputs, run through the next DIV=4 ena cycle, stop #1 after the edge that ends it.
  task automatic go(input logic r, input logic c, input logic [7:0] m,
                    input logic ee, input logic qq, input logic [7:0] d);
    ras_n = r; cas_n = c; ma = m; e = ee; q = qq; mem_q = d;
    while (cyc % 4 != 0) tick();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    ras_n = 1'b1; cas_n = 1'b1; e = 1'b0; q = 1'b0; ma = 8'h00; mem_q = 8'h00;
    #1;
    chk("rst_ena",   a_ena,    0);
    chk("rst_addr",  a_addr,   0);
    chk("rst_pulse", {a_avld, a_ref, a_cerr, a_vvld, a_cvld}, 0);
    chk("rst_data",  {a_vid, a_cpu}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;

    for (int k = 1; k <= 28; k++) begin
      tick();
      chk($sformatf("ena4_c%0d", k), a_ena, (k % 4 == 0));
      chk($sformatf("ena2_c%0d", k), c_ena, (k % 2 == 0));
      chk($sformatf("ena7_c%0d", k), d_ena, (k % 7 == 0));
    end
    tick();

    // row then column
    go(1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 8'h00);
    chk("ras_only_avld", a_avld, 0);
    chk("ras_only_ref",  a_ref,  0);
    go(1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 8'h00);
    chk("rc_addr",  a_addr, 16'h1234);
    chk("rc_avld",  a_avld, 1);
    chk("rc_cerr",  a_cerr, 0);
    chk("rc_ref",   a_ref,  0);
    tick();
    chk("rc_avld_1clk", a_avld, 0);
    go(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("ras_rise_done_ref", a_ref, 0);

    // refresh-only
    go(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
    chk("ref_row_ref", a_ref, 0);
    go(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("ref_pulse", a_ref,  1);
    chk("ref_addr",  a_addr, 16'h1234);
    tick();
    chk("ref_1clk",  a_ref,  0);
    go(1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 8'h00);
    chk("lone_cas_err",  a_cerr, 1);
    chk("lone_cas_avld", a_avld, 0);
    chk("lone_cas_addr", a_addr, 16'h1234);
    go(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("cas_rise_err", a_cerr, 0);

    // data capture
    go(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5);
    chk("qr_vid",      a_vid,  8'hA5);
    chk("qr_vvld",     a_vvld, 1);
    chk("qr_cvld",     a_cvld, 0);
    chk("qr_fall_vld", b_vvld, 0);
    chk("qr_fall_vid", b_vid,  8'h00);
    go(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h3C);
    chk("ef_cpu",      a_cpu,  8'h3C);
    chk("ef_cvld",     a_cvld, 1);
    chk("ef_vid_hold", a_vid,  8'hA5);
    chk("ef_vvld",     a_vvld, 0);
    chk("qf_vid",      b_vid,  8'h3C);
    chk("qf_vvld",     b_vvld, 1);
    chk("qf_cpu",      b_cpu,  8'h3C);
    chk("qf_cvld",     b_cvld, 1);

    // simultaneous RAS/CAS fall
    go(1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00);
    chk("sim_cerr", a_cerr, 1);
    chk("sim_avld", a_avld, 0);
    chk("sim_addr", a_addr, 16'h1234);
    go(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    go(1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00);
    chk("sim_next_addr", a_addr, 16'h0177);
    chk("sim_next_avld", a_avld, 1);
    chk("sim_next_cerr", a_cerr, 0);
    go(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("sim_close_ref", a_ref, 0);

    // reset between RAS and CAS
    go(1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    #1;
    chk("mid_rst_addr",  a_addr, 0);
    chk("mid_rst_data",  {a_vid, a_cpu, b_vid, b_cpu}, 0);
    chk("mid_rst_ena",   {a_ena, c_ena, d_ena}, 0);
    chk("mid_rst_pulse", {a_avld, a_ref, a_cerr, a_vvld, a_cvld}, 0);
    cas_n = 1'b0; ma = 8'h10;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("rel_ena4_c%0d", k), a_ena, (k % 4 == 0));
      chk($sformatf("rel_ena2_c%0d", k), c_ena, (k % 2 == 0));
      chk($sformatf("rel_ena7_c%0d", k), d_ena, (k % 7 == 0));
      if (k == 5) begin
        chk("rel_cas_err",  a_cerr, 1);
        chk("rel_cas_avld", a_avld, 0);
        chk("rel_cas_addr", a_addr, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
